// File: rtl/cache_pkg.sv
// Shared types and helpers for the data-cache line fill path.
package cache_pkg;

  localparam int LINE_BITS   = 128;
  localparam int OFFSET_BITS = 4;
  localparam int MAX_ADDR_W  = 64;

  typedef enum logic [2:0] {
    IDLE,
    WB_WAIT,
    WB,
    RD_WAIT,
    RD_CAP,
    RESP
  } fill_state_t;

  function automatic logic [MAX_ADDR_W-1:0] line_align(input logic [MAX_ADDR_W-1:0] addr);
    return {addr[MAX_ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter modelling memory wait cycles; load sets it to MEM_LATENCY, dec stops at zero.
module mem_wait_counter #(
  parameter int MEM_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CNT_W = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(MEM_LATENCY);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// Data-cache miss handler: optional victim write-back, then line refill returned to the cache.
module cache_line_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_LATENCY   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic                     req_dirty,
  input  logic [ADDRESS_WIDTH-1:0] req_victim_addr,
  input  logic [LINE_BITS-1:0]     req_victim_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ADDRESS_WIDTH-1:0] resp_addr,
  output logic [LINE_BITS-1:0]     resp_data,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_write_addr,
  output logic [LINE_BITS-1:0]     mem_wd,
  output logic [ADDRESS_WIDTH-1:0] mem_read_addr,
  input  logic [LINE_BITS-1:0]     mem_rd
);

  fill_state_t state, state_nxt;
  logic        accept;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;

  mem_wait_counter #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_wait_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  // The read wait is reloaded on entry to WB so the WB cycle itself counts as
  // the first read wait cycle; at MEM_LATENCY=0 WB then goes straight to RD_CAP.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept    = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = req_dirty ? WB_WAIT : RD_WAIT;
        end
      end
      WB_WAIT: begin
        if (cnt_zero) begin
          cnt_load  = 1'b1;
          state_nxt = WB;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WB: begin
        cnt_dec   = !cnt_zero;
        state_nxt = cnt_zero ? RD_CAP : RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt_zero) begin
          state_nxt = RD_CAP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RD_CAP: state_nxt = RESP;
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_addr      <= '0;
      resp_data      <= '0;
      mem_we         <= 1'b0;
      mem_write_addr <= '0;
      mem_wd         <= '0;
      mem_read_addr  <= '0;
    end else begin
      state  <= state_nxt;
      mem_we <= (state_nxt == WB);
      if (accept) begin
        req_ready     <= 1'b0;
        mem_read_addr <= ADDRESS_WIDTH'(line_align(MAX_ADDR_W'(req_addr)));
        if (req_dirty) begin
          mem_write_addr <= ADDRESS_WIDTH'(line_align(MAX_ADDR_W'(req_victim_addr)));
          mem_wd         <= req_victim_data;
        end
      end
      if (state == RD_CAP) begin
        resp_valid <= 1'b1;
        resp_addr  <= mem_read_addr;
        resp_data  <= mem_rd;
      end
      if ((state == RESP) && resp_ready) begin
        resp_valid <= 1'b0;
        req_ready  <= 1'b1;
      end
    end
  end

endmodule
